// File: rtl/ladder_ctrl.sv
// ladder_ctrl: Montgomery-ladder sequencer issuing INIT/STEP/RECOVER commands to a point datapath.
// Latency: one command in flight; SCAN skips leading zeros at one bit per cycle unless LADDER_CONST_TIME_EN.
// Backpressure: commands hold on cmd_valid until cmd_ready; the next command waits for rsp_done.
module ladder_ctrl #(
    parameter int SCALAR_LEN = 256,
    parameter int IDX_W      = $clog2(SCALAR_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SCALAR_LEN-1:0] k,
    output logic                  cmd_valid,
    output logic [1:0]            cmd_op,
    output logic                  cmd_bit,
    output logic [IDX_W-1:0]      bit_idx,
    input  logic                  cmd_ready,
    input  logic                  rsp_done,
    output logic                  busy,
    output logic                  finish,
    output logic                  zero_k
);

    typedef enum logic [3:0] {
        IDLE,
        SCAN,
        INIT_ISSUE,
        INIT_WAIT,
        STEP_ISSUE,
        STEP_WAIT,
        REC_ISSUE,
        REC_WAIT,
        DONE
    } state_t;

    localparam logic [1:0]       OP_INIT = 2'b00;
    localparam logic [1:0]       OP_STEP = 2'b01;
    localparam logic [1:0]       OP_REC  = 2'b10;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(SCALAR_LEN - 1);

    state_t                state;
    logic [SCALAR_LEN-1:0] k_reg;
    logic [IDX_W-1:0]      idx;      // scan position, then first STEP index
    logic                  no_step;  // top set bit was bit 0: go straight to RECOVER
    logic                  xfer;

    assign xfer = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_reg     <= '0;
            idx       <= '0;
            no_step   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_INIT;
            cmd_bit   <= 1'b0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
            zero_k    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg   <= k;
                        zero_k  <= 1'b0;
                        busy    <= 1'b1;
                        no_step <= 1'b0;
                        idx     <= TOP_IDX;
`ifdef LADDER_CONST_TIME_EN
                        // Ladder starts from (O,P) and walks every bit.
                        state     <= INIT_ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_INIT;
                        cmd_bit   <= 1'b0;
                        bit_idx   <= '0;
`else
                        state <= SCAN;
`endif
                    end
                end
                SCAN: begin
                    if (k_reg[idx]) begin
                        // Top set bit is absorbed by loading (P,2P).
                        state     <= INIT_ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_INIT;
                        cmd_bit   <= 1'b1;
                        bit_idx   <= '0;
                        no_step   <= (idx == '0);
                        idx       <= idx - 1'b1;
                    end else if (idx == '0) begin
                        state  <= DONE;
                        finish <= 1'b1;
                        zero_k <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                INIT_ISSUE: begin
                    if (xfer) begin
                        cmd_valid <= 1'b0;
                        state     <= INIT_WAIT;
                    end
                end
                INIT_WAIT: begin
                    if (rsp_done) begin
                        cmd_valid <= 1'b1;
                        if (no_step) begin
                            state   <= REC_ISSUE;
                            cmd_op  <= OP_REC;
                            cmd_bit <= 1'b0;
                            bit_idx <= '0;
                        end else begin
                            state   <= STEP_ISSUE;
                            cmd_op  <= OP_STEP;
                            cmd_bit <= k_reg[idx];
                            bit_idx <= idx;
                        end
                    end
                end
                STEP_ISSUE: begin
                    if (xfer) begin
                        cmd_valid <= 1'b0;
                        state     <= STEP_WAIT;
                    end
                end
                STEP_WAIT: begin
                    if (rsp_done) begin
                        cmd_valid <= 1'b1;
                        if (bit_idx != '0) begin
                            state   <= STEP_ISSUE;
                            cmd_op  <= OP_STEP;
                            cmd_bit <= k_reg[bit_idx - 1'b1];
                            bit_idx <= bit_idx - 1'b1;
                        end else begin
                            state   <= REC_ISSUE;
                            cmd_op  <= OP_REC;
                            cmd_bit <= 1'b0;
                            bit_idx <= '0;
                        end
                    end
                end
                REC_ISSUE: begin
                    if (xfer) begin
                        cmd_valid <= 1'b0;
                        state     <= REC_WAIT;
                    end
                end
                REC_WAIT: begin
                    if (rsp_done) begin
                        state  <= DONE;
                        finish <= 1'b1;
                        zero_k <= (k_reg == '0);
                    end
                end
                DONE: begin
                    finish <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ladder_ctrl.sv
// Randomized bench for ladder_ctrl (SCALAR_LEN=8) against a command-list reference model.
module tb_ladder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] k = '0;
    logic       cmd_ready = 1'b1;
    logic       rsp_done = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_bit;
    logic [2:0] bit_idx;
    logic       busy;
    logic       finish;
    logic       zero_k;

    ladder_ctrl #(.SCALAR_LEN(8), .IDX_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_bit   (cmd_bit),
        .bit_idx   (bit_idx),
        .cmd_ready (cmd_ready),
        .rsp_done  (rsp_done),
        .busy      (busy),
        .finish    (finish),
        .zero_k    (zero_k)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic       b;
        logic [2:0] idx;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Datapath-side model state
    bit   outstanding = 0;
    int   rsp_cnt = 0;
    bit   rand_mode = 0;
    bit   spurious = 0;
    bit   stall_req = 0;
    bit   stall_done = 0;
    int   stall_left = 0;
    bit   prev_vld = 0;
    bit   prev_xfer = 0;
    cmd_t prev_cmd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected command list straight from the ladder rules.
    task automatic build_exp(input logic [7:0] kk);
        int m;
        exp_q.delete();
`ifdef LADDER_CONST_TIME_EN
        exp_q.push_back({2'b00, 1'b0, 3'd0});
        m = 8;
`else
        m = -1;
        for (int i = 7; i >= 0; i--)
            if (kk[i] && m < 0) m = i;
        if (m < 0) return;
        exp_q.push_back({2'b00, 1'b1, 3'd0});
`endif
        for (int i = m - 1; i >= 0; i--)
            exp_q.push_back({2'b01, kk[i], 3'(i)});
        exp_q.push_back({2'b10, 1'b0, 3'd0});
    endtask

    // Called #1 after a rising edge: check protocol, drive inputs, advance one cycle.
    task automatic step(input bit start_v, input bit rst_v);
        cmd_t cur;
        cur = {cmd_op, cmd_bit, bit_idx};
        if (prev_vld && !prev_xfer) begin
            chk("hold_vld", 32'(cmd_valid), 32'd1);
            chk("hold_cmd", 32'(cur), 32'(prev_cmd));
        end
        if (prev_xfer) chk("vld_drop", 32'(cmd_valid), 32'd0);
        if (cmd_valid) chk("single_cmd", 32'(outstanding), 32'd0);

        rsp_done = 1'b0;
        if (outstanding) begin
            if (rsp_cnt == 0) begin
                rsp_done = 1'b1;
                outstanding = 0;
            end else begin
                rsp_cnt--;
            end
        end else if (spurious && $urandom_range(0, 3) == 0) begin
            rsp_done = 1'b1;
        end

        if (stall_left > 0) begin
            cmd_ready = 1'b0;
            stall_left--;
        end else if (stall_req && !stall_done && cmd_valid && cmd_op == 2'b01 && bit_idx == 3'd4) begin
            cmd_ready = 1'b0;
            stall_left = 2;
            stall_done = 1;
        end else begin
            cmd_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end

        prev_xfer = cmd_valid && cmd_ready && !rst_v;
        if (prev_xfer) begin
            obs_q.push_back(cur);
            outstanding = 1;
            rsp_cnt = (rand_mode ? $urandom_range(1, 4) : 2) - 1;
        end
        prev_vld = cmd_valid && !rst_v;
        prev_cmd = cur;
        start = start_v;
        rst = rst_v;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] kk, output int cyc);
        build_exp(kk);
        obs_q.delete();
        k = kk;
        step(1'b1, 1'b0);
        k = 8'($urandom);
        cyc = 0;
        while (!finish && cyc < 400) begin
            chk("busy_run", 32'(busy), 32'd1);
            step(spurious && $urandom_range(0, 5) == 0, 1'b0);
            cyc++;
        end
        chk("finish_seen", 32'(finish), 32'd1);
        chk("busy_at_finish", 32'(busy), 32'd1);
        chk("zero_k", 32'(zero_k), 32'(kk == 8'd0));
        chk("cmd_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk("cmd", (i < obs_q.size()) ? 32'(obs_q[i]) : 32'h3f, 32'(exp_q[i]));
        step(1'b0, 1'b0);
        chk("finish_pulse", 32'(finish), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("zero_k_hold", 32'(zero_k), 32'(kk == 8'd0));
    endtask

    initial begin
        int  cyc;
        int  c1;
        int  c2;
        bit  hit;
        logic [7:0] kk;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 32'(cmd_valid), 32'd0);
        chk("rst_op", 32'(cmd_op), 32'd0);
        chk("rst_bit", 32'(cmd_bit), 32'd0);
        chk("rst_idx", 32'(bit_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fin_zk", 32'({finish, zero_k}), 32'd0);

        run(8'h05, cyc);
        run(8'h00, cyc);
`ifndef LADDER_CONST_TIME_EN
        chk("scan_cycles_k0", 32'(cyc), 32'd8);
`endif
        run(8'h01, cyc);

        stall_req = 1;
        run(8'hB4, cyc);
        stall_req = 0;
        chk("stall_hit", 32'(stall_done), 32'd1);

        // Reset in STEP_WAIT of index 3, with a response landing on the same edge sometimes.
        build_exp(8'h9A);
        obs_q.delete();
        k = 8'h9A;
        step(1'b1, 1'b0);
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (outstanding && obs_q.size() > 0 && obs_q[$].op == 2'b01 && obs_q[$].idx == 3'd3)
                hit = 1;
            else
                step(1'b0, 1'b0);
        end
        chk("rst_point_reached", 32'(hit), 32'd1);
        step(1'b1, 1'b1);
        outstanding = 0;
        prev_vld = 0;
        prev_xfer = 0;
        rst = 1'b0;
        chk("mid_rst_vld", 32'(cmd_valid), 32'd0);
        chk("mid_rst_cmd", 32'({cmd_op, cmd_bit, bit_idx}), 32'd0);
        chk("mid_rst_flags", 32'({busy, finish, zero_k}), 32'd0);
        run(8'h05, cyc);

        spurious = 1;
        run(8'h05, cyc);
        run(8'h00, cyc);

        rand_mode = 1;
        for (int n = 0; n < 40; n++) begin
            kk = 8'($urandom) >> $urandom_range(0, 8);
            run(kk, cyc);
        end

        rand_mode = 0;
        spurious = 0;
        run(8'h05, c1);
        run(8'h80, c2);
`ifdef LADDER_CONST_TIME_EN
        chk("const_time_cycles", 32'(c1), 32'(c2));
        run(8'h00, c2);
        chk("const_time_k0", 32'(c1), 32'(c2));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ladder_ctrl.md
LADDER_CTRL -- requirements
Module: ladder_ctrl

Interface
REQ-001 Parameter: SCALAR_LEN, 256, scalar width in bits (>=2).
REQ-002 Parameter: IDX_W, $clog2(SCALAR_LEN), width of bit_idx.
REQ-003 Port: clk input 1, single clock; all logic on rising edge.
REQ-004 Port: rst input 1, synchronous active-high reset.
REQ-005 Port: start input 1, request scalar multiplication; sampled only in IDLE.
REQ-006 Port: k input SCALAR_LEN, scalar; captured into internal register on accepted start.
REQ-007 Port: cmd_valid output 1, command to point datapath pending.
REQ-008 Port: cmd_op output 2, 2'b00 INIT, 2'b01 STEP, 2'b10 RECOVER; 2'b11 never driven.
REQ-009 Port: cmd_bit output 1, INIT: 1 = load (P,2P), 0 = load (O,P); STEP: current scalar bit; RECOVER: 0.
REQ-010 Port: bit_idx output IDX_W, scalar index of current STEP; 0 for INIT/RECOVER.
REQ-011 Port: cmd_ready input 1, datapath accepts command; transfer when cmd_valid && cmd_ready.
REQ-012 Port: rsp_done input 1, one-cycle pulse, datapath finished last accepted command.
REQ-013 Port: busy output 1, high from cycle after accepted start until finish cycle inclusive.
REQ-014 Port: finish output 1, one-cycle pulse at completion.
REQ-015 Port: zero_k output 1, valid with finish; high when captured k == 0; holds until next accepted start.

Function
REQ-016 FSM states: IDLE, SCAN, INIT_ISSUE, INIT_WAIT, STEP_ISSUE, STEP_WAIT, REC_ISSUE, REC_WAIT, DONE.
REQ-017 IDLE: start high -> capture k, clear zero_k, go SCAN; start in any other state SHALL be ignored.
REQ-018 SCAN (no macro): one index per cycle from SCALAR_LEN-1 downward; first set bit m -> INIT_ISSUE with cmd_bit=1, next STEP index m-1; index 0 examined and clear -> zero_k=1, DONE, no command issued.
REQ-019 m == 0: INIT_WAIT SHALL go directly to REC_ISSUE (no STEP).
REQ-020 *_ISSUE states: cmd_valid=1, cmd_op/cmd_bit/bit_idx stable until transfer; on transfer go to matching *_WAIT with cmd_valid=0 next cycle.
REQ-021 *_WAIT states: rsp_done -> next state; rsp_done in any other state SHALL be ignored.
REQ-022 STEP_WAIT: bit_idx > 0 -> decrement, STEP_ISSUE; bit_idx == 0 -> REC_ISSUE.
REQ-023 REC_WAIT + rsp_done -> DONE; DONE asserts finish for one cycle, returns to IDLE next cycle.
REQ-024 Exactly one command outstanding at any time; a new command SHALL NOT be issued before rsp_done of previous.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE from any state, including mid-command; outputs after that edge: cmd_valid=0, cmd_op=0, cmd_bit=0, bit_idx=0, busy=0, finish=0, zero_k=0, scalar register=0.
REQ-026 rst SHALL take priority over start and rsp_done in the same cycle.

Configuration
REQ-027 Macro LADDER_CONST_TIME_EN defined: SCAN state skipped (IDLE -> INIT_ISSUE with cmd_bit=0), STEP over all indices SCALAR_LEN-1..0, k == 0 runs full sequence with zero_k=1 at finish; command count and cycle count independent of k for fixed datapath timing.
REQ-028 Macro undefined: leading-zero skip per REQ-018/REQ-019.

Verification (SCALAR_LEN=8, cmd_ready=1, rsp_done 2 cycles after transfer unless stated)
REQ-029 k=8'h05, no macro -> commands INIT/1, STEP/bit0 idx1, STEP/bit1 idx0, RECOVER; one finish; zero_k=0.
REQ-030 k=8'h00, no macro -> cmd_valid never high, finish after 8 SCAN cycles, zero_k=1; k=8'h01 -> INIT/1 then RECOVER only.
REQ-031 LADDER_CONST_TIME_EN, k=8'h05 then k=8'h80 -> each INIT/0 + 8 STEPs idx 7..0 + RECOVER, identical start-to-finish cycle counts.
REQ-032 cmd_ready low 3 cycles during STEP_ISSUE idx 4 -> cmd_valid, cmd_op, cmd_bit, bit_idx unchanged until transfer.
REQ-033 rst pulse during STEP_WAIT idx 3 -> next cycle all outputs at reset values; new start with k=8'h05 yields REQ-029 sequence exactly.
REQ-034 start pulsed while busy and rsp_done pulsed in IDLE/ISSUE states -> no extra command, sequence and finish unaffected.
